// File: rtl/ysyx_mem_arbiter_if.sv
// rtl/ysyx_mem_arbiter_if.sv - IFU/LSU request and shared memory bus bundle for ysyx_mem_arbiter.
// The master modport is the arbiter. The slave modport is the requesters and memory around it.
interface ysyx_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  ifu_arvalid;
  logic [ADDR_W-1:0]     ifu_araddr;
  logic [DATA_W-1:0]     ifu_rdata;
  logic                  ifu_rvalid;

  logic                  lsu_arvalid;
  logic [ADDR_W-1:0]     lsu_araddr;
  logic                  lsu_awvalid;
  logic [ADDR_W-1:0]     lsu_awaddr;
  logic [DATA_W-1:0]     lsu_wdata;
  logic [DATA_W/8-1:0]   lsu_wstrb;
  logic [DATA_W-1:0]     lsu_rdata;
  logic                  lsu_rvalid;
  logic                  lsu_bvalid;

  logic                  mem_arvalid;
  logic [ADDR_W-1:0]     mem_araddr;
  logic                  mem_awvalid;
  logic [ADDR_W-1:0]     mem_awaddr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_rvalid;
  logic                  mem_bvalid;

  logic                  grant_lsu;

  modport master (
    input  ifu_arvalid, ifu_araddr,
    output ifu_rdata, ifu_rvalid,
    input  lsu_arvalid, lsu_araddr, lsu_awvalid, lsu_awaddr, lsu_wdata, lsu_wstrb,
    output lsu_rdata, lsu_rvalid, lsu_bvalid,
    output mem_arvalid, mem_araddr, mem_awvalid, mem_awaddr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_rvalid, mem_bvalid,
    output grant_lsu
  );

  modport slave (
    output ifu_arvalid, ifu_araddr,
    input  ifu_rdata, ifu_rvalid,
    output lsu_arvalid, lsu_araddr, lsu_awvalid, lsu_awaddr, lsu_wdata, lsu_wstrb,
    input  lsu_rdata, lsu_rvalid, lsu_bvalid,
    input  mem_arvalid, mem_araddr, mem_awvalid, mem_awaddr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_rvalid, mem_bvalid,
    input  grant_lsu
  );
endinterface

// File: rtl/ysyx_mem_arbiter.sv
// rtl/ysyx_mem_arbiter.sv - Whole-transaction arbiter sharing one memory port between IFU and LSU.
// YSYX_ARB_RR_EN selects round-robin on ties; without it the LSU always wins a tie.
module ysyx_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  ysyx_mem_arbiter_if.master bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IFU = 2'd1,
    RD_LSU = 2'd2,
    WR_LSU = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                last_lsu_q, last_lsu_d;

  logic                ifu_req;
  logic                lsu_req;
  logic                lsu_wins;

  assign ifu_req = bus.ifu_arvalid;
  assign lsu_req = bus.lsu_arvalid | bus.lsu_awvalid;

`ifdef YSYX_ARB_RR_EN
  // On a tie the port that did not win last time goes first.
  assign lsu_wins = lsu_req & (~ifu_req | ~last_lsu_q);
`else
  logic unused_last_lsu;
  assign unused_last_lsu = last_lsu_q;
  assign lsu_wins = lsu_req;
`endif

  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    last_lsu_d = last_lsu_q;
    case (state_q)
      IDLE: begin
        if (lsu_wins) begin
          last_lsu_d = 1'b1;
          if (bus.lsu_awvalid) begin
            state_d  = WR_LSU;
            awaddr_d = bus.lsu_awaddr;
            wdata_d  = bus.lsu_wdata;
            wstrb_d  = bus.lsu_wstrb;
          end else begin
            state_d  = RD_LSU;
            araddr_d = bus.lsu_araddr;
          end
        end else if (ifu_req) begin
          last_lsu_d = 1'b0;
          state_d    = RD_IFU;
          araddr_d   = bus.ifu_araddr;
        end
      end
      RD_IFU, RD_LSU: begin
        if (bus.mem_rvalid) state_d = IDLE;
      end
      WR_LSU: begin
        if (bus.mem_bvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      araddr_q   <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      last_lsu_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      last_lsu_q <= last_lsu_d;
    end
  end

  // Request valids come straight from the state, so they drop on the same edge the response lands.
  assign bus.mem_arvalid = (state_q == RD_IFU) | (state_q == RD_LSU);
  assign bus.mem_awvalid = (state_q == WR_LSU);
  assign bus.mem_araddr  = araddr_q;
  assign bus.mem_awaddr  = awaddr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_wstrb   = wstrb_q;
  assign bus.grant_lsu   = (state_q == RD_LSU) | (state_q == WR_LSU);

  assign bus.ifu_rvalid  = bus.mem_rvalid & (state_q == RD_IFU);
  assign bus.lsu_rvalid  = bus.mem_rvalid & (state_q == RD_LSU);
  assign bus.lsu_bvalid  = bus.mem_bvalid & (state_q == WR_LSU);
  assign bus.ifu_rdata   = bus.mem_rdata;
  assign bus.lsu_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// tb/tb_ysyx_mem_arbiter.sv - Directed vectors, starvation sequence and randomized model check of ysyx_mem_arbiter.
module tb_ysyx_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef YSYX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [31:0] A_IFU = 32'h8000_0000;
  localparam logic [31:0] A_LR  = 32'h8000_2000;
  localparam logic [31:0] A_LW  = 32'h8000_1000;
  localparam logic [31:0] WD    = 32'hDEAD_BEEF;
  localparam logic [3:0]  WS    = 4'b0011;
  localparam logic [31:0] RDAT  = 32'h0000_0413;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ysyx_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One record per cycle: inputs {rst,ifu_ar,lsu_ar,lsu_aw,mem_r,mem_b}, outputs {ar,aw,grant_lsu,ifu_rv,lsu_rv,lsu_bv}.
  typedef struct {
    logic [5:0]  in_v;
    logic [5:0]  ex_v;
    logic [31:0] addr;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [5:0] i, input logic [5:0] e, input logic [31:0] a);
    vec_t v;
    v.in_v = i; v.ex_v = e; v.addr = a;
    tbl.push_back(v);
  endtask

  function automatic logic [5:0] outs();
    return {bus.mem_arvalid, bus.mem_awvalid, bus.grant_lsu,
            bus.ifu_rvalid, bus.lsu_rvalid, bus.lsu_bvalid};
  endfunction

  // Arbitration rule: a lone requester wins; on a tie the LSU wins unless round-robin says otherwise.
  function automatic bit pick_lsu(bit ireq, bit lreq, bit last_lsu);
    if (!lreq) return 1'b0;
    if (!ireq) return 1'b1;
    return RR ? !last_lsu : 1'b1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    bit exp_lsu;
    int kind, lat;
    logic [31:0] m_araddr, m_awaddr, m_wdata;
    logic [3:0] m_wstrb;
    bit m_last_lsu;
    bit ifu_pend, lrd_pend, lwr_pend;
    logic [31:0] ifu_addr, lr_addr, lw_addr, lw_data;
    logic [3:0] lw_strb;
    bit rst_now, drop_i, drop_l, mr, mb, ireq, lreq;
    logic [5:0] ev;

    // Directed vectors
    add(6'b110000, 6'b000000, 0);
    add(6'b010000, 6'b000000, 0);
    add(6'b010000, 6'b100000, A_IFU);
    add(6'b010000, 6'b100000, A_IFU);
    add(6'b010000, 6'b100000, A_IFU);
    add(6'b010010, 6'b100100, A_IFU);
    add(6'b000011, 6'b000000, 0);
    add(6'b000100, 6'b000000, 0);
    add(6'b000100, 6'b011000, A_LW);
    add(6'b000101, 6'b011001, A_LW);
    add(6'b000000, 6'b000000, 0);
    add(6'b010000, 6'b000000, 0);
    add(6'b010010, 6'b100100, A_IFU);
    add(6'b011000, 6'b000000, 0);
    add(6'b011000, 6'b101000, A_LR);
    add(6'b011010, 6'b101010, A_LR);
    add(6'b010000, 6'b000000, 0);
    add(6'b010010, 6'b100100, A_IFU);
    add(6'b000000, 6'b000000, 0);
    add(6'b001100, 6'b000000, 0);
    add(6'b001110, 6'b011000, A_LW);
    add(6'b001101, 6'b011001, A_LW);
    add(6'b001000, 6'b000000, 0);
    add(6'b001001, 6'b101000, A_LR);
    add(6'b001010, 6'b101010, A_LR);
    add(6'b010000, 6'b000000, 0);
    add(6'b010000, 6'b100000, A_IFU);
    add(6'b110000, 6'b100000, A_IFU);
    add(6'b000010, 6'b000000, 0);
    add(6'b000000, 6'b000000, 0);
    add(6'b010000, 6'b000000, 0);
    add(6'b000000, 6'b100000, A_IFU);
    add(6'b001000, 6'b100000, A_IFU);
    add(6'b001010, 6'b100100, A_IFU);
    add(6'b001000, 6'b000000, 0);
    add(6'b001010, 6'b101010, A_LR);
    add(6'b000000, 6'b000000, 0);

    rst = 1'b1;
    bus.ifu_arvalid = 1'b1; bus.ifu_araddr = A_IFU;
    bus.lsu_arvalid = 1'b0; bus.lsu_araddr = A_LR;
    bus.lsu_awvalid = 1'b0; bus.lsu_awaddr = A_LW;
    bus.lsu_wdata = WD; bus.lsu_wstrb = WS;
    bus.mem_rdata = RDAT; bus.mem_rvalid = 1'b0; bus.mem_bvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 6'b000000);
    chk("reset_araddr", bus.mem_araddr, 0);
    chk("reset_awaddr", bus.mem_awaddr, 0);
    chk("reset_wdata", bus.mem_wdata, 0);
    chk("reset_wstrb", bus.mem_wstrb, 0);

    foreach (tbl[i]) begin
      {rst, bus.ifu_arvalid, bus.lsu_arvalid, bus.lsu_awvalid, bus.mem_rvalid, bus.mem_bvalid} = tbl[i].in_v;
      #2;
      chk($sformatf("vec%0d_outs", i), outs(), tbl[i].ex_v);
      if (tbl[i].ex_v[5]) chk($sformatf("vec%0d_araddr", i), bus.mem_araddr, tbl[i].addr);
      if (tbl[i].ex_v[4]) begin
        chk($sformatf("vec%0d_awaddr", i), bus.mem_awaddr, tbl[i].addr);
        chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, WD);
        chk($sformatf("vec%0d_wstrb", i), bus.mem_wstrb, WS);
      end
      if (tbl[i].ex_v[2]) chk($sformatf("vec%0d_ifu_rdata", i), bus.ifu_rdata, RDAT);
      if (tbl[i].ex_v[1]) chk($sformatf("vec%0d_lsu_rdata", i), bus.lsu_rdata, RDAT);
      @(posedge clk);
      #1;
    end

    // Both ports request continuously; last grant went to the LSU.
    rst = 1'b0;
    bus.ifu_arvalid = 1'b1; bus.lsu_arvalid = 1'b1; bus.lsu_awvalid = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_bvalid = 1'b0;
    for (int t = 0; t < 10; t++) begin
      got = 1'b0;
      for (int k = 0; k < 4 && !got; k++) begin
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        #1;
        if (bus.mem_arvalid) got = 1'b1;
      end
      chk($sformatf("cont%0d_granted", t), got, 1'b1);
      if (got) begin
        exp_lsu = RR ? (t % 2 == 1) : 1'b1;
        chk($sformatf("cont%0d_owner", t), bus.grant_lsu, exp_lsu);
        bus.mem_rvalid = 1'b1;
        #1;
        chk($sformatf("cont%0d_resp", t), {bus.ifu_rvalid, bus.lsu_rvalid}, {!exp_lsu, exp_lsu});
      end
    end
    @(posedge clk);
    #1;
    bus.mem_rvalid = 1'b0; bus.ifu_arvalid = 1'b0; bus.lsu_arvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against a transaction-level model
    kind = 0; lat = 0;
    m_araddr = 0; m_awaddr = 0; m_wdata = 0; m_wstrb = 0; m_last_lsu = 1'b0;
    ifu_pend = 0; lrd_pend = 0; lwr_pend = 0;
    ifu_addr = 0; lr_addr = 0; lw_addr = 0; lw_data = 0; lw_strb = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_now = ($urandom_range(0, 63) == 0);
      if (!ifu_pend && $urandom_range(0, 1) == 1) begin ifu_pend = 1; ifu_addr = $urandom; end
      if (!lrd_pend && $urandom_range(0, 2) == 0) begin lrd_pend = 1; lr_addr = $urandom; end
      if (!lwr_pend && $urandom_range(0, 2) == 0) begin
        lwr_pend = 1; lw_addr = $urandom; lw_data = $urandom; lw_strb = 4'($urandom);
      end
      drop_i = (kind == 1) && ($urandom_range(0, 3) == 0);
      drop_l = (kind >= 2) && ($urandom_range(0, 3) == 0);
      mr = ((kind == 1) || (kind == 2)) && (lat == 0);
      mb = (kind == 3) && (lat == 0);
      if ($urandom_range(0, 7) == 0) begin
        if (kind == 0) {mr, mb} = 2'($urandom);
        else if (kind == 3) mr = 1'b1;
        else mb = 1'b1;
      end

      rst = rst_now;
      bus.ifu_arvalid = ifu_pend && !drop_i;
      bus.ifu_araddr  = drop_i ? $urandom : ifu_addr;
      bus.lsu_arvalid = lrd_pend && !drop_l;
      bus.lsu_araddr  = drop_l ? $urandom : lr_addr;
      bus.lsu_awvalid = lwr_pend && !drop_l;
      bus.lsu_awaddr  = lw_addr;
      bus.lsu_wdata   = lw_data;
      bus.lsu_wstrb   = lw_strb;
      bus.mem_rvalid  = mr;
      bus.mem_bvalid  = mb;
      bus.mem_rdata   = $urandom;
      #2;

      ev = {(kind == 1) || (kind == 2), kind == 3, kind >= 2,
            mr && kind == 1, mr && kind == 2, mb && kind == 3};
      chk($sformatf("rnd%0d_outs", c), outs(), ev);
      if (ev[5]) chk($sformatf("rnd%0d_araddr", c), bus.mem_araddr, m_araddr);
      if (ev[4]) chk($sformatf("rnd%0d_wr", c), {bus.mem_awaddr, bus.mem_wdata, bus.mem_wstrb},
                     {m_awaddr, m_wdata, m_wstrb});
      chk($sformatf("rnd%0d_rdata", c), {bus.ifu_rdata, bus.lsu_rdata}, {bus.mem_rdata, bus.mem_rdata});

      if (rst_now) begin
        kind = 0; m_araddr = 0; m_awaddr = 0; m_wdata = 0; m_wstrb = 0; m_last_lsu = 1'b0;
      end else if (kind == 0) begin
        ireq = bus.ifu_arvalid;
        lreq = bus.lsu_arvalid || bus.lsu_awvalid;
        if (ireq || lreq) begin
          if (pick_lsu(ireq, lreq, m_last_lsu)) begin
            m_last_lsu = 1'b1;
            if (bus.lsu_awvalid) begin
              kind = 3; m_awaddr = lw_addr; m_wdata = lw_data; m_wstrb = lw_strb;
            end else begin
              kind = 2; m_araddr = lr_addr;
            end
          end else begin
            m_last_lsu = 1'b0;
            kind = 1; m_araddr = ifu_addr;
          end
          lat = $urandom_range(0, 3);
        end
      end else if ((kind != 3 && mr) || (kind == 3 && mb)) begin
        if (kind == 1) ifu_pend = 0;
        else if (kind == 2) lrd_pend = 0;
        else lwr_pend = 0;
        kind = 0;
      end else begin
        lat--;
      end
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
